// File: rtl/icache_axi_rd_bridge_if.sv
// rtl/icache_axi_rd_bridge_if.sv - refill request and AXI4 read-channel bundle for the icache bridge
interface icache_axi_rd_bridge_if #(
    parameter int ID_W = 4
);
    logic            rstart;
    logic [31:0]     raddr;
    logic [7:0]      rlen;
    logic            rok;
    logic [31:0]     rdata;
    logic            busy;
    logic            arvalid;
    logic            arready;
    logic [31:0]     araddr;
    logic [ID_W-1:0] arid;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            rvalid;
    logic            rready;
    logic [31:0]     rdata_axi;
    logic [1:0]      rresp;
    logic            rlast;
    logic [ID_W-1:0] rid;
    logic            err_resp;
    logic            err_proto;

    // master: the bridge (cache-side responder, AXI read master)
    modport master (
        input  rstart, raddr, rlen, arready, rvalid, rdata_axi, rresp, rlast, rid,
        output rok, rdata, busy, arvalid, araddr, arid, arlen, arsize, arburst, rready,
               err_resp, err_proto
    );

    // slave: the environment (cache plus AXI memory)
    modport slave (
        output rstart, raddr, rlen, arready, rvalid, rdata_axi, rresp, rlast, rid,
        input  rok, rdata, busy, arvalid, araddr, arid, arlen, arsize, arburst, rready,
               err_resp, err_proto
    );
endinterface

// File: rtl/icache_axi_rd_bridge.sv
// rtl/icache_axi_rd_bridge.sv - icache refill to AXI4 INCR read bridge with 4 KiB split
module icache_axi_rd_bridge #(
    parameter int          ID_W        = 4,
    parameter int unsigned ARID_VAL    = 0,
    parameter int          BOUNDARY_LS = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    icache_axi_rd_bridge_if.master bus
);
    localparam logic [ID_W-1:0] ARID        = ID_W'(ARID_VAL);
    localparam logic [31:0]     BOUND_BYTES = 32'd1 << BOUNDARY_LS;

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_e;

    state_e      state_q;
    logic        arvalid_q;
    logic [31:0] araddr_q;
    logic [7:0]  arlen_q;
    logic        rok_q;
    logic [31:0] rdata_q;
    logic        busy_q;
    logic        err_resp_q;
    logic        err_proto_q;
    logic [8:0]  beat_q;
    logic [8:0]  exp_q;
    logic        sec_valid_q;
    logic [31:0] sec_addr_q;
    logic [8:0]  sec_beats_q;
    logic        pend_valid_q;
    logic [31:0] pend_addr_q;
    logic [7:0]  pend_len_q;

    logic [31:0] src_addr_d;
    logic [7:0]  src_len_d;
    logic [31:0] base_d;
    logic [31:0] room_d;
    logic [31:0] sec_addr_d;
    logic [8:0]  total_d;
    logic [8:0]  first_beats_d;
    logic [8:0]  sec_beats_d;
    logic        split_d;
    logic        start_d;
    logic        r_hs_d;
    logic [8:0]  beat_inc_d;
    logic        hit_last_d;

    // A waiting request always wins over a fresh strobe so ordering is preserved.
    always_comb begin
        src_addr_d    = pend_valid_q ? pend_addr_q : bus.raddr;
        src_len_d     = pend_valid_q ? pend_len_q  : bus.rlen;
        base_d        = src_addr_d & ~32'd3;
        total_d       = {1'b0, src_len_d} + 9'd1;
        room_d        = (BOUND_BYTES - (base_d & (BOUND_BYTES - 32'd1))) >> 2;
        split_d       = {23'd0, total_d} > room_d;
        first_beats_d = split_d ? room_d[8:0] : total_d;
        sec_beats_d   = total_d - room_d[8:0];
        sec_addr_d    = base_d + {room_d[29:0], 2'b00};
        start_d       = pend_valid_q | bus.rstart;
        r_hs_d        = (state_q == S_R) && bus.rvalid && (bus.rid == ARID);
        beat_inc_d    = beat_q + 9'd1;
        hit_last_d    = (beat_inc_d == exp_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            arvalid_q    <= 1'b0;
            araddr_q     <= 32'd0;
            arlen_q      <= 8'd0;
            rok_q        <= 1'b0;
            rdata_q      <= 32'd0;
            busy_q       <= 1'b0;
            err_resp_q   <= 1'b0;
            err_proto_q  <= 1'b0;
            beat_q       <= 9'd0;
            exp_q        <= 9'd0;
            sec_valid_q  <= 1'b0;
            sec_addr_q   <= 32'd0;
            sec_beats_q  <= 9'd0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 32'd0;
            pend_len_q   <= 8'd0;
        end else begin
            rok_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_d) begin
                        state_q     <= S_AR;
                        arvalid_q   <= 1'b1;
                        araddr_q    <= base_d;
                        arlen_q     <= 8'(first_beats_d - 9'd1);
                        exp_q       <= first_beats_d;
                        sec_valid_q <= split_d;
                        sec_addr_q  <= sec_addr_d;
                        sec_beats_q <= sec_beats_d;
                        busy_q      <= 1'b1;
                    end
                end
                S_AR: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= S_R;
                        beat_q    <= 9'd0;
                    end
                end
                S_R: begin
                    if (r_hs_d) begin
                        rok_q   <= 1'b1;
                        rdata_q <= bus.rdata_axi;
                        beat_q  <= beat_inc_d;
                        if (bus.rresp != 2'b00) begin
                            err_resp_q <= 1'b1;
                        end
                        if (bus.rlast && !hit_last_d) begin
                            // Truncated burst: abandon the rest of this request.
                            err_proto_q <= 1'b1;
                            sec_valid_q <= 1'b0;
                            state_q     <= S_IDLE;
                            busy_q      <= 1'b0;
                        end else if (hit_last_d) begin
                            if (!bus.rlast) begin
                                err_proto_q <= 1'b1;
                            end
                            if (sec_valid_q) begin
                                state_q     <= S_AR;
                                arvalid_q   <= 1'b1;
                                araddr_q    <= sec_addr_q;
                                arlen_q     <= 8'(sec_beats_q - 9'd1);
                                exp_q       <= sec_beats_q;
                                sec_valid_q <= 1'b0;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // In IDLE a held request is launched this cycle, so the slot frees up
            // and can take a strobe arriving at the same time.
            if (state_q == S_IDLE) begin
                if (pend_valid_q) begin
                    pend_valid_q <= bus.rstart;
                    pend_addr_q  <= bus.raddr;
                    pend_len_q   <= bus.rlen;
                end
            end else if (bus.rstart) begin
                if (pend_valid_q) begin
                    err_proto_q <= 1'b1;
                end else begin
                    pend_valid_q <= 1'b1;
                    pend_addr_q  <= bus.raddr;
                    pend_len_q   <= bus.rlen;
                end
            end
        end
    end

    assign bus.arvalid   = arvalid_q;
    assign bus.araddr    = araddr_q;
    assign bus.arlen     = arlen_q;
    assign bus.arid      = ARID;
    assign bus.arsize    = 3'b010;
    assign bus.arburst   = 2'b01;
    assign bus.rready    = (state_q == S_R);
    assign bus.rok       = rok_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.err_resp  = err_resp_q;
    assign bus.err_proto = err_proto_q;
endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// tb/tb_icache_axi_rd_bridge.sv - scoreboard bench for the icache AXI read bridge
module tb_icache_axi_rd_bridge;
    localparam int ID_W = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    icache_axi_rd_bridge_if #(.ID_W(ID_W)) bus ();

    icache_axi_rd_bridge #(
        .ID_W(ID_W),
        .ARID_VAL(0),
        .BOUNDARY_LS(12)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    int          vectors     = 0;
    int          miscompares = 0;
    ar_t         ar_exp[$];
    logic [31:0] data_exp[$];
    int          rok_cnt        = 0;
    logic        last_rok_busy   = 1'b1;
    logic        last_rok_rready = 1'b1;
    int          ar_delay   = 1;
    int          err_beat   = 0;
    int          early_last = 0;
    bit          no_last    = 1'b0;
    bit          bad_id     = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    initial begin : rok_monitor
        logic [31:0] e;
        forever begin
            @(negedge clock);
            if (reset && bus.rok) begin
                rok_cnt++;
                last_rok_busy   = bus.busy;
                last_rok_rready = bus.rready;
                if (data_exp.size() > 0) begin
                    e = data_exp.pop_front();
                    check_val("rdata", bus.rdata, e);
                end else begin
                    check_val("rok_extra", data_exp.size(), 1);
                end
            end
        end
    end

    initial begin : axi_slave
        ar_t a;
        int  nb;
        bit  aborted;
        bus.arready   = 1'b0;
        bus.rvalid    = 1'b0;
        bus.rdata_axi = 32'd0;
        bus.rresp     = 2'b00;
        bus.rlast     = 1'b0;
        bus.rid       = '0;
        forever begin
            @(negedge clock);
            if (reset && bus.arvalid) begin
                aborted = 1'b0;
                for (int i = 0; i < ar_delay; i++) begin
                    @(negedge clock);
                    if (!reset) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    check_val("arvalid_held", bus.arvalid, 1);
                    check_val("arid", bus.arid, 0);
                    check_val("arsize", bus.arsize, 3'b010);
                    check_val("arburst", bus.arburst, 2'b01);
                    if (ar_exp.size() > 0) begin
                        a = ar_exp.pop_front();
                        check_val("araddr", bus.araddr, a.addr);
                        check_val("arlen", bus.arlen, a.len);
                    end else begin
                        check_val("ar_extra", ar_exp.size(), 1);
                    end
                    nb = int'(bus.arlen) + 1;
                    bus.arready = 1'b1;
                    @(negedge clock);
                    bus.arready = 1'b0;
                    if (bad_id) begin
                        bus.rvalid    = 1'b1;
                        bus.rid       = 4'h5;
                        bus.rdata_axi = 32'hDEAD_0005;
                        bus.rlast     = 1'b1;
                        @(negedge clock);
                    end
                    for (int b = 1; b <= nb; b++) begin
                        bus.rvalid    = 1'b1;
                        bus.rid       = '0;
                        bus.rdata_axi = $urandom;
                        bus.rresp     = (b == err_beat) ? 2'b10 : 2'b00;
                        bus.rlast     = (b == early_last) || (b == nb && !no_last);
                        data_exp.push_back(bus.rdata_axi);
                        @(negedge clock);
                        if (b == early_last) break;
                    end
                    bus.rvalid = 1'b0;
                    bus.rlast  = 1'b0;
                    bus.rresp  = 2'b00;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [7:0] l);
        bus.rstart = 1'b1;
        bus.raddr  = a;
        bus.rlen   = l;
        @(negedge clock);
        bus.rstart = 1'b0;
        bus.raddr  = 32'd0;
        bus.rlen   = 8'd0;
    endtask

    task automatic wait_done(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 3000) begin
            @(negedge clock);
            n++;
            quiet = (bus.busy || bus.arvalid) ? 0 : quiet + 1;
        end
        check_val({tag, "_done"}, n < 3000, 1);
        check_val({tag, "_ar_left"}, ar_exp.size(), 0);
        check_val({tag, "_data_left"}, data_exp.size(), 0);
    endtask

    task automatic clear_knobs();
        ar_delay   = 1;
        err_beat   = 0;
        early_last = 0;
        no_last    = 1'b0;
        bad_id     = 1'b0;
        rok_cnt    = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        ar_exp.delete();
        data_exp.delete();
        clear_knobs();
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_arvalid"}, bus.arvalid, 0);
        check_val({tag, "_araddr"}, bus.araddr, 0);
        check_val({tag, "_arlen"}, bus.arlen, 0);
        check_val({tag, "_rready"}, bus.rready, 0);
        check_val({tag, "_rok"}, bus.rok, 0);
        check_val({tag, "_rdata"}, bus.rdata, 0);
        check_val({tag, "_busy"}, bus.busy, 0);
        check_val({tag, "_err_resp"}, bus.err_resp, 0);
        check_val({tag, "_err_proto"}, bus.err_proto, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int n;
        bus.rstart = 1'b0;
        bus.raddr  = 32'd0;
        bus.rlen   = 8'd0;
        @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clock);

        // Single aligned burst, arready after two cycles
        clear_knobs();
        ar_delay = 2;
        ar_exp.push_back('{32'h8000_0010, 8'd3});
        issue(32'h8000_0010, 8'd3);
        wait_done("basic");
        check_val("basic_roks", rok_cnt, 4);
        check_val("basic_busy_at_last", last_rok_busy, 0);
        check_val("basic_err_resp", bus.err_resp, 0);
        check_val("basic_err_proto", bus.err_proto, 0);

        // 4 KiB crossing splits into two bursts
        clear_knobs();
        ar_exp.push_back('{32'h8000_0FF8, 8'd1});
        ar_exp.push_back('{32'h8000_1000, 8'd1});
        issue(32'h8000_0FF8, 8'd3);
        wait_done("split");
        check_val("split_roks", rok_cnt, 4);
        check_val("split_err_proto", bus.err_proto, 0);
        check_val("split_err_resp", bus.err_resp, 0);

        // SLVERR on beat 2 still forwards every beat
        clear_knobs();
        err_beat = 2;
        ar_exp.push_back('{32'h0000_1000, 8'd3});
        issue(32'h0000_1000, 8'd3);
        wait_done("slverr");
        check_val("slverr_roks", rok_cnt, 4);
        check_val("slverr_err_resp", bus.err_resp, 1);
        check_val("slverr_err_proto", bus.err_proto, 0);

        // Foreign rid beat is ignored
        clear_knobs();
        bad_id = 1'b1;
        ar_exp.push_back('{32'h0000_0020, 8'd1});
        issue(32'h0000_0020, 8'd1);
        wait_done("badid");
        check_val("badid_roks", rok_cnt, 2);
        check_val("badid_err_proto", bus.err_proto, 0);

        // Maximum length, low address bits ignored, page-aligned so no split
        clear_knobs();
        ar_exp.push_back('{32'h1000_0000, 8'd255});
        issue(32'h1000_0003, 8'd255);
        wait_done("max");
        check_val("max_roks", rok_cnt, 256);
        check_val("max_busy_at_last", last_rok_busy, 0);

        // Early rlast on beat 2 of 4
        do_reset();
        early_last = 2;
        ar_exp.push_back('{32'h0000_0040, 8'd3});
        issue(32'h0000_0040, 8'd3);
        wait_done("early");
        check_val("early_roks", rok_cnt, 2);
        check_val("early_err_proto", bus.err_proto, 1);
        check_val("early_idle_at_last", last_rok_rready, 0);
        check_val("early_busy_at_last", last_rok_busy, 0);

        // Missing rlast on the final beat
        do_reset();
        no_last = 1'b1;
        ar_exp.push_back('{32'h0000_0100, 8'd1});
        issue(32'h0000_0100, 8'd1);
        wait_done("nolast");
        check_val("nolast_roks", rok_cnt, 2);
        check_val("nolast_err_proto", bus.err_proto, 1);

        // Pending slot: second request queued, third dropped
        do_reset();
        ar_exp.push_back('{32'h0000_0200, 8'd3});
        ar_exp.push_back('{32'h0000_0300, 8'd1});
        issue(32'h0000_0200, 8'd3);
        n = 0;
        while (!bus.rready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check_val("pend_reached_r", bus.rready, 1);
        issue(32'h0000_0300, 8'd1);
        check_val("pend_no_err_yet", bus.err_proto, 0);
        issue(32'h0000_0400, 8'd0);
        wait_done("pend");
        check_val("pend_roks", rok_cnt, 6);
        check_val("pend_err_proto", bus.err_proto, 1);

        // Asynchronous reset while AR is outstanding
        do_reset();
        ar_delay = 10;
        ar_exp.push_back('{32'h0000_0500, 8'd0});
        issue(32'h0000_0500, 8'd0);
        n = 0;
        while (!bus.arvalid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_val("async_arvalid_seen", bus.arvalid, 1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async");
        @(negedge clock);
        do_reset();
        ar_exp.push_back('{32'h0000_0600, 8'd1});
        issue(32'h0000_0600, 8'd1);
        wait_done("after_reset");
        check_val("after_reset_roks", rok_cnt, 2);
        check_val("after_reset_err_proto", bus.err_proto, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
